// File: rtl/mem2apb_pkg.sv
// Shared types and helpers for the core-to-APB bridge.
package mem2apb_pkg;

  // Bridge sequencing: one transfer in flight, APB SETUP/ACCESS, then a
  // single response cycle back to the core.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Width needed to count up to n, never less than one bit so a disabled
  // timeout (n = 0) still yields a legal vector width.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem2apb_bridge_if.sv
// APB3 bus bundle. The initiator uses Master, the peripheral node uses Slave.
interface APB_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles spent waiting for PREADY and flags the last allowed
// cycle. With TIMEOUT_CYCLES = 0 the counter is removed and never fires.
module apb_timeout_cnt
  import mem2apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_ctrl;
    assign unused_ctrl = clr_i ^ en_i ^ clk_i ^ rst_ni;
    assign tc_o        = 1'b0;
  end else begin : g_on
    // The counter holds the number of wait cycles already spent; when it
    // reads N-1 the current wait cycle is the N-th, so the count reaches N
    // exactly as the bridge gives up.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (en_i) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign tc_o = (cnt_q == LAST);
  end

endmodule

// File: rtl/mem2apb_bridge.sv
// Single-outstanding bridge from the core req/gnt/rvalid data port to an
// APB3 initiator, with PREADY timeout and partial-write rejection.
module mem2apb_bridge
  import mem2apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0]   addr_i,
  input  logic                        we_i,
  input  logic [APB_DATA_WIDTH/8-1:0] be_i,
  input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
  output logic                        rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  APB_BUS.Master                      apb_master
);

  state_e                      state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                        pwrite_q, pwrite_d;
  logic [APB_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                        err_q, err_d;

  logic reject;
  logic cnt_clr;
  logic cnt_en;
  logic timeout;

  // APB3 has no strobes, so a write that does not cover the whole word
  // cannot be performed faithfully and is refused without touching the bus.
  assign reject  = we_i && (be_i != '1);
  assign cnt_clr = (state_q == IDLE) && req_i && !reject;
  assign cnt_en  = (state_q == ACCESS) && !apb_master.pready;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_o   (timeout)
  );

  // Next-state and datapath capture for the transfer sequencer.
  // NOTE: every signal gets its default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    gnt_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          paddr_d  = {addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
          pwrite_d = we_i;
          pwdata_d = wdata_i;
          if (reject) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked before the timeout so a completion on the last
        // allowed cycle is reported normally.
        if (apb_master.pready) begin
          rdata_d = pwrite_q ? '0 : apb_master.prdata;
          err_d   = apb_master.pslverr;
          state_d = RESP;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Bus controls decode straight from the state register, so leaving
  // ACCESS (completion, timeout or reset) drops PSEL/PENABLE at that edge.
  assign apb_master.psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb_master.penable = (state_q == ACCESS);
  assign apb_master.paddr   = paddr_q;
  assign apb_master.pwdata  = pwdata_q;
  assign apb_master.pwrite  = pwrite_q;

  assign rvalid_o = (state_q == RESP);
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  // Word-aligned APB: the byte offset of the request address is dropped.
  logic unused_addr;
  assign unused_addr = ^addr_i[1:0];

endmodule

// File: tb/tb_mem2apb_bridge.sv
// Directed bench for mem2apb_bridge with a hand-driven APB peripheral.
module tb_mem2apb_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  int n_checks = 0;
  int n_bad    = 0;

  APB_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

  mem2apb_bridge #(
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .addr_i     (addr_i),
    .we_i       (we_i),
    .be_i       (be_i),
    .wdata_i    (wdata_i),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .apb_master (apb.Master)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs checked a further #1 later, well clear of either clock edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic bus(input string tag, input logic sel, input logic en);
    check({tag, ".psel"}, {31'd0, apb.psel}, {31'd0, sel});
    check({tag, ".penable"}, {31'd0, apb.penable}, {31'd0, en});
  endtask

  task automatic resp(input string tag, input logic v, input logic [31:0] d, input logic e);
    check({tag, ".rvalid"}, {31'd0, rvalid_o}, {31'd0, v});
    if (v) begin
      check({tag, ".rdata"}, rdata_o, d);
      check({tag, ".err"}, {31'd0, err_o}, {31'd0, e});
    end
  endtask

  task automatic start(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = d;
  endtask

  task automatic apb_drive(input logic rdy, input logic [31:0] d, input logic se);
    apb.pready = rdy; apb.prdata = d; apb.pslverr = se;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0;
    req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
    apb_drive(1'b0, 32'h0, 1'b0);
    tick(); tick();
    settle();
    check("rst.gnt", {31'd0, gnt_o}, 32'd0);
    check("rst.rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst.rdata", rdata_o, 32'd0);
    check("rst.err", {31'd0, err_o}, 32'd0);
    bus("rst", 1'b0, 1'b0);
    check("rst.pwrite", {31'd0, apb.pwrite}, 32'd0);
    check("rst.paddr", apb.paddr, 32'd0);
    check("rst.pwdata", apb.pwdata, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Zero-wait read.
    start(32'h1A10_1004, 1'b0, 4'h0, 32'h0);
    settle(); check("rd.c0.gnt", {31'd0, gnt_o}, 32'd1); bus("rd.c0", 1'b0, 1'b0);
    tick(); req_i = 1'b0;
    settle(); bus("rd.c1", 1'b1, 1'b0); check("rd.c1.paddr", apb.paddr, 32'h1A10_1004);
    check("rd.c1.pwrite", {31'd0, apb.pwrite}, 32'd0); check("rd.c1.gnt", {31'd0, gnt_o}, 32'd0);
    tick(); apb_drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    settle(); bus("rd.c2", 1'b1, 1'b1); check("rd.c2.paddr", apb.paddr, 32'h1A10_1004);
    tick(); apb_drive(1'b0, 32'h0, 1'b0);
    settle(); resp("rd.c3", 1'b1, 32'hDEAD_BEEF, 1'b0); bus("rd.c3", 1'b0, 1'b0);
    tick();
    settle(); resp("rd.c4", 1'b0, 32'h0, 1'b0);

    // Full-word write with three wait states; PREADY is also presented in
    // SETUP, where it must be ignored.
    start(32'h1A10_0008, 1'b1, 4'hF, 32'h0000_00A5);
    settle(); check("wr.c0.gnt", {31'd0, gnt_o}, 32'd1);
    tick(); req_i = 1'b0; wdata_i = 32'hFFFF_FFFF; apb_drive(1'b1, 32'h1234_5678, 1'b0);
    settle(); bus("wr.c1", 1'b1, 1'b0); check("wr.c1.pwrite", {31'd0, apb.pwrite}, 32'd1);
    for (int c = 2; c <= 4; c++) begin
      tick(); apb_drive(1'b0, 32'h1234_5678, 1'b0);
      settle();
      bus($sformatf("wr.c%0d", c), 1'b1, 1'b1);
      check($sformatf("wr.c%0d.pwdata", c), apb.pwdata, 32'h0000_00A5);
      check($sformatf("wr.c%0d.pwrite", c), {31'd0, apb.pwrite}, 32'd1);
      check($sformatf("wr.c%0d.paddr", c), apb.paddr, 32'h1A10_0008);
      resp($sformatf("wr.c%0d", c), 1'b0, 32'h0, 1'b0);
    end
    tick(); apb_drive(1'b1, 32'h1234_5678, 1'b0);
    settle(); bus("wr.c5", 1'b1, 1'b1); check("wr.c5.pwdata", apb.pwdata, 32'h0000_00A5);
    tick(); apb_drive(1'b0, 32'h0, 1'b0);
    settle(); resp("wr.c6", 1'b1, 32'h0, 1'b0); bus("wr.c6", 1'b0, 1'b0);
    tick();

    // Partial write is refused without any APB activity.
    start(32'h1A10_0010, 1'b1, 4'h3, 32'hAAAA_5555);
    settle(); check("pw.c0.gnt", {31'd0, gnt_o}, 32'd1); bus("pw.c0", 1'b0, 1'b0);
    tick(); req_i = 1'b0;
    settle(); resp("pw.c1", 1'b1, 32'h0, 1'b1); bus("pw.c1", 1'b0, 1'b0);
    tick();
    settle(); resp("pw.c2", 1'b0, 32'h0, 1'b0); bus("pw.c2", 1'b0, 1'b0);

    // Read with slave error on an unaligned address.
    start(32'h1A10_100B, 1'b0, 4'h1, 32'h0);
    tick(); req_i = 1'b0;
    settle(); check("se.c1.paddr", apb.paddr, 32'h1A10_1008);
    tick(); apb_drive(1'b1, 32'hCAFE_0001, 1'b1);
    settle(); bus("se.c2", 1'b1, 1'b1);
    tick(); apb_drive(1'b0, 32'h0, 1'b0);
    settle(); resp("se.c3", 1'b1, 32'hCAFE_0001, 1'b1);
    tick();

    // Timeout after four ACCESS cycles with no PREADY.
    start(32'h1A10_2000, 1'b0, 4'h0, 32'h0);
    tick(); req_i = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      settle();
      bus($sformatf("to.c%0d", c), 1'b1, 1'b1);
      resp($sformatf("to.c%0d", c), 1'b0, 32'h0, 1'b0);
    end
    tick();
    settle(); bus("to.c6", 1'b0, 1'b0); resp("to.c6", 1'b1, 32'h0, 1'b1);
    tick();
    settle(); resp("to.c7", 1'b0, 32'h0, 1'b0);

    // Follow-up read after the timeout completes normally.
    start(32'h1A10_2004, 1'b0, 4'h0, 32'h0);
    tick(); req_i = 1'b0;
    tick(); apb_drive(1'b1, 32'h0000_1234, 1'b0);
    tick(); apb_drive(1'b0, 32'h0, 1'b0);
    settle(); resp("to2.c3", 1'b1, 32'h0000_1234, 1'b0);
    tick();

    // PREADY on the final allowed ACCESS cycle beats the timeout.
    start(32'h1A10_2008, 1'b0, 4'h0, 32'h0);
    tick(); req_i = 1'b0;
    tick(); tick(); tick();
    tick(); apb_drive(1'b1, 32'h55AA_55AA, 1'b0);
    settle(); bus("tie.c5", 1'b1, 1'b1);
    tick(); apb_drive(1'b0, 32'h0, 1'b0);
    settle(); resp("tie.c6", 1'b1, 32'h55AA_55AA, 1'b0);
    tick();

    // Reset during ACCESS.
    start(32'h1A10_3000, 1'b0, 4'h0, 32'h0);
    tick(); req_i = 1'b0;
    tick(); rst_ni = 1'b0;
    settle(); bus("mr.c2", 1'b1, 1'b1);
    tick();
    settle(); bus("mr.c3", 1'b0, 1'b0); resp("mr.c3", 1'b0, 32'h0, 1'b0);
    check("mr.c3.rdata", rdata_o, 32'h0);
    tick(); rst_ni = 1'b1;
    settle(); resp("mr.c4", 1'b0, 32'h0, 1'b0);

    // Back-to-back reads with req_i held high.
    start(32'h1A10_4000, 1'b0, 4'h0, 32'h0);
    settle(); check("bb.c0.gnt", {31'd0, gnt_o}, 32'd1);
    tick();
    settle(); check("bb.c1.gnt", {31'd0, gnt_o}, 32'd0);
    tick(); apb_drive(1'b1, 32'h1111_1111, 1'b0);
    settle(); check("bb.c2.gnt", {31'd0, gnt_o}, 32'd0);
    tick(); apb_drive(1'b0, 32'h0, 1'b0); addr_i = 32'h1A10_4004;
    settle(); resp("bb.c3", 1'b1, 32'h1111_1111, 1'b0); check("bb.c3.gnt", {31'd0, gnt_o}, 32'd0);
    tick();
    settle(); check("bb.c4.gnt", {31'd0, gnt_o}, 32'd1); resp("bb.c4", 1'b0, 32'h0, 1'b0);
    tick(); req_i = 1'b0;
    settle(); bus("bb.c5", 1'b1, 1'b0); check("bb.c5.paddr", apb.paddr, 32'h1A10_4004);
    tick(); apb_drive(1'b1, 32'h2222_2222, 1'b0);
    tick(); apb_drive(1'b0, 32'h0, 1'b0);
    settle(); resp("bb.c7", 1'b1, 32'h2222_2222, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
